// File: rtl/hmem_arb_pkg.sv
// rtl/hmem_arb_pkg.sv - shared types and defaults for the hmem line-burst arbiter
package hmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST_I = 2'd1,
        ST_BURST_D = 2'd2
    } state_e;

    localparam int BEATS_DEF  = 8;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 64;

    // Round-robin flag values: which port was served last
    localparam logic LRG_I = 1'b0;
    localparam logic LRG_D = 1'b1;

    function automatic int line_off_w(input int beats, input int data_w);
        return $clog2(beats * data_w / 8);
    endfunction

endpackage

// File: rtl/hmem_arb.sv
// rtl/hmem_arb.sv - round-robin arbiter muxing I/D cache line bursts onto one hmem port
module hmem_arb
    import hmem_arb_pkg::*;
#(
    parameter int BEATS  = BEATS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_vld,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wrdy,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_vld,
    output logic              d_done,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rdy
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = line_off_w(BEATS, DATA_W);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEATS - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               m_req_q;
    logic               m_we_q;
    logic [ADDR_W-1:0]  m_addr_q;
    logic               lrg_q;

    logic in_i;
    logic in_d;
    logic last_beat;
    logic grant_i;

    assign in_i      = (state_q == ST_BURST_I);
    assign in_d      = (state_q == ST_BURST_D);
    assign last_beat = m_rdy && (cnt_q == CNT_LAST);
    // On a tie the port not served last wins
    assign grant_i   = i_req && (!d_req || (lrg_q == LRG_D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            m_req_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_addr_q <= '0;
            lrg_q    <= LRG_D;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_i) begin
                        state_q  <= ST_BURST_I;
                        m_req_q  <= 1'b1;
                        m_we_q   <= 1'b0;
                        m_addr_q <= i_addr & ADDR_MASK;
                        cnt_q    <= '0;
                    end else if (d_req) begin
                        state_q  <= ST_BURST_D;
                        m_req_q  <= 1'b1;
                        m_we_q   <= d_we;
                        m_addr_q <= d_addr & ADDR_MASK;
                        cnt_q    <= '0;
                    end
                end
                ST_BURST_I, ST_BURST_D: begin
                    if (m_rdy) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (last_beat) begin
                        state_q <= ST_IDLE;
                        m_req_q <= 1'b0;
                        lrg_q   <= in_i ? LRG_I : LRG_D;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = d_wdata;

    assign i_rdata = m_rdata;
    assign i_vld   = in_i && m_rdy;
    assign i_done  = in_i && last_beat;

    assign d_rdata = m_rdata;
    assign d_vld   = in_d && !m_we_q && m_rdy;
    assign d_wrdy  = in_d && m_we_q && m_rdy;
    assign d_done  = in_d && last_beat;

endmodule

// File: tb/tb_hmem_arb.sv
// tb/tb_hmem_arb.sv - directed self-checking bench for hmem_arb
module tb_hmem_arb;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic [63:0] i_rdata;
    logic        i_vld;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_wrdy;
    logic [63:0] d_rdata;
    logic        d_vld;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        m_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    hmem_arb #(.BEATS(8), .DATA_W(64), .ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_vld(i_vld), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wrdy(d_wrdy),
        .d_rdata(d_rdata), .d_vld(d_vld), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; m_rdata = 0; m_rdy = 1'b1;
        tick(); tick();
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got %0b exp 0", m_req); end
        n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we got %0b exp 0", m_we); end
        n_checks++; if (m_addr !== 64'h0) begin n_fail++; $display("FAIL reset_m_addr got %h exp 0", m_addr); end
        n_checks++;
        if ({i_vld, i_done, d_vld, d_wrdy, d_done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b exp 00000", {i_vld, i_done, d_vld, d_wrdy, d_done});
        end
        rst_n = 1'b1;
        m_rdy = 1'b0;
        tick();
    endtask

    task automatic test_idle_rdy();
        m_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({m_req, i_vld, i_done, d_vld, d_wrdy, d_done} !== 6'b0) begin
                n_fail++; $display("FAIL idle_rdy cycle %0d got %b exp 000000", k,
                                   {m_req, i_vld, i_done, d_vld, d_wrdy, d_done});
            end
        end
    endtask

    task automatic test_i_fill();
        i_req = 1'b1; i_addr = 64'h1038; m_rdy = 1'b1;
        tick();
        n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL ifill_m_req got %0b exp 1", m_req); end
        n_checks++; if (m_addr !== 64'h1000) begin n_fail++; $display("FAIL ifill_m_addr got %h exp 1000", m_addr); end
        n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL ifill_m_we got %0b exp 0", m_we); end
        for (int k = 0; k < 8; k++) begin
            m_rdata = 64'hA000 + 64'(k);
            #1;
            n_checks++; if (i_vld !== 1'b1) begin n_fail++; $display("FAIL ifill_vld beat %0d got %0b exp 1", k, i_vld); end
            n_checks++; if (i_rdata !== 64'hA000 + 64'(k)) begin n_fail++; $display("FAIL ifill_rdata beat %0d got %h exp %h", k, i_rdata, 64'hA000 + 64'(k)); end
            n_checks++; if (i_done !== (k == 7)) begin n_fail++; $display("FAIL ifill_done beat %0d got %0b exp %0b", k, i_done, (k == 7)); end
            n_checks++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL ifill_d_vld beat %0d got %0b exp 0", k, d_vld); end
            if (k == 7) i_req = 1'b0;
            tick();
        end
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL ifill_idle_m_req got %0b exp 0", m_req); end
        n_checks++; if (i_vld !== 1'b0) begin n_fail++; $display("FAIL ifill_idle_vld got %0b exp 0", i_vld); end
    endtask

    task automatic test_tie();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        m_rdy = 1'b1;
        i_req = 1'b1; i_addr = 64'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3010;
        tick();
        n_checks++; if (m_addr !== 64'h1000) begin n_fail++; $display("FAIL tie1_addr got %h exp 1000", m_addr); end
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (i_vld !== 1'b1 || d_vld !== 1'b0) begin n_fail++; $display("FAIL tie1_vld beat %0d got i=%0b d=%0b exp i=1 d=0", k, i_vld, d_vld); end
            if (k == 7) begin
                n_checks++; if (i_done !== 1'b1) begin n_fail++; $display("FAIL tie1_done got %0b exp 1", i_done); end
                i_req = 1'b0;
            end
            tick();
        end
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL tie_gap_m_req got %0b exp 0", m_req); end
        tick();
        n_checks++; if (m_req !== 1'b1 || m_addr !== 64'h3000 || m_we !== 1'b0) begin
            n_fail++; $display("FAIL tie_d_grant got req=%0b addr=%h we=%0b exp req=1 addr=3000 we=0", m_req, m_addr, m_we);
        end
        for (int k = 0; k < 8; k++) begin
            m_rdata = 64'hB000 + 64'(k);
            #1;
            n_checks++; if (d_vld !== 1'b1 || d_rdata !== 64'hB000 + 64'(k)) begin
                n_fail++; $display("FAIL tie_d_beat %0d got vld=%0b data=%h exp vld=1 data=%h", k, d_vld, d_rdata, 64'hB000 + 64'(k));
            end
            n_checks++; if (d_done !== (k == 7)) begin n_fail++; $display("FAIL tie_d_done beat %0d got %0b exp %0b", k, d_done, (k == 7)); end
            if (k == 7) begin i_req = 1'b1; i_addr = 64'h4000; end
            tick();
        end
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL tie2_gap got %0b exp 0", m_req); end
        tick();
        n_checks++; if (m_addr !== 64'h4000 || i_vld !== 1'b1) begin
            n_fail++; $display("FAIL tie2_grant got addr=%h i_vld=%0b exp addr=4000 i_vld=1", m_addr, i_vld);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin i_req = 1'b0; d_req = 1'b0; end
            tick();
        end
        tick();
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL tie_end_idle got %0b exp 0", m_req); end
    endtask

    task automatic test_write_back();
        int nw = 0;
        bit seen_done = 0;
        logic exp_done;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2040; d_wdata = 64'hD0; m_rdy = 1'b0;
        tick();
        n_checks++; if (m_we !== 1'b1 || m_addr !== 64'h2040) begin
            n_fail++; $display("FAIL wb_grant got we=%0b addr=%h exp we=1 addr=2040", m_we, m_addr);
        end
        for (int c = 0; c < 40 && !seen_done; c++) begin
            m_rdy = (c % 2 == 0);
            #1;
            exp_done = m_rdy && (nw == 7);
            n_checks++; if (m_wdata !== d_wdata) begin n_fail++; $display("FAIL wb_wdata cyc %0d got %h exp %h", c, m_wdata, d_wdata); end
            n_checks++; if (d_wrdy !== m_rdy || d_vld !== 1'b0) begin
                n_fail++; $display("FAIL wb_wrdy cyc %0d got wrdy=%0b vld=%0b exp wrdy=%0b vld=0", c, d_wrdy, d_vld, m_rdy);
            end
            n_checks++; if (d_done !== exp_done) begin n_fail++; $display("FAIL wb_done cyc %0d got %0b exp %0b", c, d_done, exp_done); end
            if (m_rdy) begin
                nw++;
                d_wdata = d_wdata + 64'h1;
            end
            if (exp_done) begin seen_done = 1; d_req = 1'b0; end
            tick();
        end
        n_checks++; if (nw != 8 || !seen_done) begin n_fail++; $display("FAIL wb_count got %0d beats done=%0b exp 8 done=1", nw, seen_done); end
        m_rdy = 1'b0;
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL wb_idle got %0b exp 0", m_req); end
    endtask

    task automatic test_req_drop();
        int ndone = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h5000; m_rdy = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (d_vld !== 1'b1) begin n_fail++; $display("FAIL drop_vld beat %0d got %0b exp 1", k, d_vld); end
            if (d_done) ndone++;
            n_checks++; if (d_done !== (k == 7)) begin n_fail++; $display("FAIL drop_done beat %0d got %0b exp %0b", k, d_done, (k == 7)); end
            if (k == 2) d_req = 1'b0;
            tick();
        end
        n_checks++; if (ndone != 1 || m_req !== 1'b0) begin
            n_fail++; $display("FAIL drop_end got done=%0d m_req=%0b exp done=1 m_req=0", ndone, m_req);
        end
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_addr = 64'h6000; m_rdy = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h7000;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_req got %0b exp 0", m_req); end
        n_checks++; if (i_vld !== 1'b0 || i_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_strobes got vld=%0b done=%0b exp 0 0", i_vld, i_done);
        end
        tick();
        n_checks++; if (i_done !== 1'b0 || m_req !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_hold got done=%0b req=%0b exp 0 0", i_done, m_req);
        end
        rst_n = 1'b1;
        tick();
        n_checks++; if (m_addr !== 64'h6000 || i_vld !== 1'b1 || m_we !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_regrant got addr=%h i_vld=%0b we=%0b exp 6000 1 0", m_addr, i_vld, m_we);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin i_req = 1'b0; d_req = 1'b0; end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle_rdy();
        test_i_fill();
        test_tie();
        test_write_back();
        test_req_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
